dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 64-bit data memory. It lets the processor core's load/store path and an external loader/debug port share one data memory.
- Grants one requester per transaction with round-robin priority.
- Drives the memory address, write and read controls.
- Holds a read for a fixed memory latency, then returns the data to the owning requester with a one-cycle valid pulse.
- Sits between the core's Data_Memory connection and the memory array.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin two-port arbiter/sequencer (core + external port)
//               for a shared data memory with fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // external loader/debug port
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The counter only ever holds values 0..MEM_LAT-1.
  localparam int c_cnt_w = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MEM_LAT - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_last;   // 0 = core granted last, 1 = ext granted last
  logic                r_owner;  // owner of the outstanding read
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;

  logic                w_idle;
  logic                w_rd_wait;
  logic                w_any;
  logic                w_sel_e;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // Winner selection and memory-side muxing; reset suppresses all strobes.
  always_comb begin
    w_idle    = (r_state == ST_IDLE) && !reset;
    w_rd_wait = (r_state == ST_RD_WAIT) && !reset;
    w_any     = w_idle && (c_req || e_req);
    if (c_req && e_req) begin
      w_sel_e = !r_last;
    end else begin
      w_sel_e = e_req;
    end
    w_we    = w_sel_e ? e_we    : c_we;
    w_addr  = w_sel_e ? e_addr  : c_addr;
    w_wdata = w_sel_e ? e_wdata : c_wdata;

    c_gnt     = w_any && !w_sel_e;
    e_gnt     = w_any &&  w_sel_e;
    mem_we    = w_any && w_we;
    mem_re    = (w_any && !w_we) || w_rd_wait;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_rd_wait) begin
      mem_addr = r_addr;
    end else if (w_any) begin
      mem_addr  = w_addr;
      mem_wdata = w_wdata;
    end
  end

  // Sequencer: latch reads, count down the latency, return data to the owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      c_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      c_rdata  <= '0;
      e_rdata  <= '0;
    end else begin
      c_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last <= w_sel_e;
            if (!w_we) begin
              r_addr  <= w_addr;
              r_owner <= w_sel_e;
              r_cnt   <= c_cnt_load;
              r_state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner) begin
              e_rdata  <= mem_rdata;
              e_rvalid <= 1'b1;
            end else begin
              c_rdata  <= mem_rdata;
              c_rvalid <= 1'b1;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter. Instance A
//               uses MEM_LAT=2, instance B uses MEM_LAT=3; both share inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, e_req, e_we;
  logic [63:0] c_addr, c_wdata, e_addr, e_wdata, mem_rdata;

  logic        a_c_gnt, a_c_rvalid, a_e_gnt, a_e_rvalid, a_mem_we, a_mem_re;
  logic [63:0] a_c_rdata, a_e_rdata, a_mem_addr, a_mem_wdata;
  logic        b_c_gnt, b_c_rvalid, b_e_gnt, b_e_rvalid, b_mem_we, b_mem_re;
  logic [63:0] b_c_rdata, b_e_rdata, b_mem_addr, b_mem_wdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(a_e_gnt), .e_rvalid(a_e_rvalid), .e_rdata(a_e_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .mem_re(a_mem_re), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(b_e_gnt), .e_rvalid(b_e_rvalid), .e_rdata(b_e_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_re(b_mem_re), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the falling edge where outputs are sampled.
  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    mem_rdata = '0;
    reset = 1;

    // ---- Reset with both requests high: nothing granted or strobed ----
    c_req = 1; e_req = 1; c_we = 1; e_we = 1;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("rst_c_gnt", a_c_gnt, 0);
      chk("rst_e_gnt", a_e_gnt, 0);
      chk("rst_we_re", {a_mem_we, a_mem_re}, 0);
      chk("rst_rvalid", {a_c_rvalid, a_e_rvalid}, 0);
      chk("rst_rdata", a_c_rdata | a_e_rdata, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      tick();
    end
    reset = 0;
    samp();
    chk("first_tie_c_gnt", a_c_gnt, 1);
    chk("first_tie_e_gnt", a_e_gnt, 0);
    tick();

    // ---- Core read, MEM_LAT=2, addr 0x40 -> 0xDEADBEEF ----
    do_reset();
    mem_rdata = 64'hDEAD_BEEF;
    c_req = 1; c_we = 0; c_addr = 64'h40;
    samp();
    chk("rd_T_c_gnt", a_c_gnt, 1);
    chk("rd_T_mem_re", a_mem_re, 1);
    chk("rd_T_mem_addr", a_mem_addr, 64'h40);
    tick();
    c_req = 0; c_addr = '0;
    for (int i = 1; i <= 2; i++) begin
      samp();
      chk("rd_wait_c_gnt", a_c_gnt, 0);
      chk("rd_wait_mem_re", a_mem_re, 1);
      chk("rd_wait_mem_we", a_mem_we, 0);
      chk("rd_wait_mem_addr", a_mem_addr, 64'h40);
      chk("rd_wait_c_rvalid", a_c_rvalid, 0);
      tick();
    end
    samp();
    chk("rd_T3_c_rvalid", a_c_rvalid, 1);
    chk("rd_T3_c_rdata", a_c_rdata, 64'hDEAD_BEEF);
    chk("rd_T3_e_rvalid", a_e_rvalid, 0);
    chk("rd_T3_mem_re", a_mem_re, 0);
    chk("rd_T3_mem_addr", a_mem_addr, 0);
    tick();
    samp();
    chk("rd_T4_c_rvalid", a_c_rvalid, 0);
    chk("rd_T4_c_rdata_hold", a_c_rdata, 64'hDEAD_BEEF);
    tick();

    // ---- Continuous writes from both ports alternate ----
    do_reset();
    c_req = 1; c_we = 1; c_addr = 64'h8;  c_wdata = 64'h1;
    e_req = 1; e_we = 1; e_addr = 64'h10; e_wdata = 64'h2;
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("wr_c_gnt", a_c_gnt, (i % 2 == 0) ? 1 : 0);
      chk("wr_e_gnt", a_e_gnt, (i % 2 == 1) ? 1 : 0);
      chk("wr_mem_we", a_mem_we, 1);
      chk("wr_mem_re", a_mem_re, 0);
      chk("wr_mem_addr", a_mem_addr, (i % 2 == 0) ? 64'h8 : 64'h10);
      chk("wr_mem_wdata", a_mem_wdata, (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end

    // ---- Ext read pending blocks core write until e_rvalid cycle ----
    do_reset();
    mem_rdata = 64'h1234;
    e_req = 1; e_we = 0; e_addr = 64'h20;
    samp();
    chk("xr_T_e_gnt", a_e_gnt, 1);
    chk("xr_T_mem_addr", a_mem_addr, 64'h20);
    tick();
    e_req = 0; e_addr = '0;
    c_req = 1; c_we = 1; c_addr = 64'h8; c_wdata = 64'h5;
    for (int i = 1; i <= 2; i++) begin
      samp();
      chk("xr_wait_c_gnt", a_c_gnt, 0);
      chk("xr_wait_mem_we", a_mem_we, 0);
      chk("xr_wait_mem_addr", a_mem_addr, 64'h20);
      tick();
    end
    samp();
    chk("xr_T3_e_rvalid", a_e_rvalid, 1);
    chk("xr_T3_e_rdata", a_e_rdata, 64'h1234);
    chk("xr_T3_c_rvalid", a_c_rvalid, 0);
    chk("xr_T3_c_gnt", a_c_gnt, 1);
    chk("xr_T3_mem_we", a_mem_we, 1);
    chk("xr_T3_mem_wdata", a_mem_wdata, 64'h5);
    tick();
    c_req = 0;

    // ---- MEM_LAT=3 read aborted by reset in second RD_WAIT cycle ----
    do_reset();
    mem_rdata = 64'hCAFE;
    c_req = 1; c_we = 0; c_addr = 64'h60;
    samp();
    chk("ab_T_c_gnt", b_c_gnt, 1);
    tick();
    c_req = 0; c_addr = '0;
    samp();
    chk("ab_T1_mem_re", b_mem_re, 1);
    chk("ab_T1_mem_addr", b_mem_addr, 64'h60);
    tick();
    reset = 1;
    samp();
    chk("ab_rst_mem_re", b_mem_re, 0);
    chk("ab_rst_c_rvalid", b_c_rvalid, 0);
    tick();
    reset = 0;
    c_req = 1; c_we = 1; c_addr = 64'h8; c_wdata = 64'h7;
    e_req = 1; e_we = 1; e_addr = 64'h10; e_wdata = 64'h9;
    samp();
    chk("ab_tie_c_gnt", b_c_gnt, 1);
    chk("ab_tie_e_gnt", b_e_gnt, 0);
    chk("ab_tie_c_rvalid", b_c_rvalid, 0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("ab_no_rvalid", {b_c_rvalid, b_e_rvalid}, 0);
      chk("ab_c_rdata", b_c_rdata, 0);
      tick();
    end

    // ---- Core req pulsed during ext RD_WAIT is never granted ----
    do_reset();
    mem_rdata = 64'h55;
    e_req = 1; e_we = 0; e_addr = 64'h30;
    samp();
    chk("dr_T_e_gnt", a_e_gnt, 1);
    tick();
    e_req = 0; e_addr = '0;
    c_req = 1; c_we = 1; c_addr = 64'h18; c_wdata = 64'h3;
    samp();
    chk("dr_T1_c_gnt", a_c_gnt, 0);
    chk("dr_T1_mem_we", a_mem_we, 0);
    tick();
    idle_inputs();
    for (int i = 2; i <= 4; i++) begin
      samp();
      chk("dr_c_gnt", a_c_gnt, 0);
      chk("dr_mem_we", a_mem_we, 0);
      chk("dr_e_rvalid", a_e_rvalid, (i == 3) ? 1 : 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
